// File: rtl/m_stage_dm_pkg.sv
// Shared definitions for the memory-access stage: op encodings, store size codes
// and the default data-memory depth.
package m_stage_dm_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LW   = 3'd1,
    OP_LH   = 3'd2,
    OP_LHU  = 3'd3,
    OP_LB   = 3'd4,
    OP_LBU  = 3'd5,
    OP_SW   = 3'd6,
    OP_SHB  = 3'd7
  } mem_op_e;

  // Sub-select for OP_SHB
  localparam logic SZ_SB = 1'b0;
  localparam logic SZ_SH = 1'b1;

  localparam int unsigned DM_DEPTH_WORDS = 1024;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SHB);
  endfunction

endpackage

// File: rtl/m_stage_dm_byte_ext.sv
// Load lane selection and sign/zero extension. Purely combinational; returns 0
// for any op that is not a load. Error gating is left to the caller so this can
// later be reused for unaligned-load helpers.
module dm_byte_ext
  import m_stage_dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  mem_op_e     mem_op_i,
  output logic [31:0] rdata_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Pick the addressed half/byte lane, then extend according to the op.
  always_comb begin
    rdata_o  = '0;
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    case (byte_off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    case (mem_op_i)
      OP_LW:   rdata_o = word_i;
      OP_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  rdata_o = {16'h0000, half_sel};
      OP_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  rdata_o = {24'h000000, byte_sel};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/m_stage_dm.sv
// Memory-access stage: word-addressed data memory with byte/half/word store
// lane merging, combinational extended loads, and a registered store trace.
module m_stage_dm
  import m_stage_dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int unsigned AW          = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  mem_op,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        range_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  // Compared in 33 bits so a full 32-bit address never wraps into range.
  localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;

  mem_op_e     op;
  logic [AW-1:0] widx;
  logic [31:0] rd_word;
  logic [31:0] ext_rdata;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic [31:0] wr_word;
  logic        commit;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        trace_valid_q, trace_valid_d;
  logic [31:0] trace_pc_q,    trace_pc_d;
  logic [31:0] trace_addr_q,  trace_addr_d;
  logic [31:0] trace_data_q,  trace_data_d;

  assign op      = mem_op_e'(mem_op);
  assign widx    = addr[AW+1:2];
  assign rd_word = mem_q[widx];

  // Alignment and range classification of the current access.
  always_comb begin
    align_err = 1'b0;
    case (op)
      OP_LW, OP_SW:   align_err = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU:  align_err = addr[0];
      OP_SHB:         align_err = (size == SZ_SH) && addr[0];
      default:        align_err = 1'b0;
    endcase
    range_err = (op != OP_NONE) && ({1'b0, addr} >= LIMIT_BYTES);
  end

  dm_byte_ext u_byte_ext (
    .word_i     (rd_word),
    .byte_off_i (addr[1:0]),
    .mem_op_i   (op),
    .rdata_o    (ext_rdata)
  );

  assign rdata = (align_err || range_err) ? 32'h0 : ext_rdata;

  // Store lane enables, replicated store data and the merged word to write.
  always_comb begin
    lane_be   = 4'b0000;
    lane_data = wdata;
    case (op)
      OP_SW: lane_be = 4'b1111;
      OP_SHB: begin
        if (size == SZ_SH) begin
          lane_be   = addr[1] ? 4'b1100 : 4'b0011;
          lane_data = {2{wdata[15:0]}};
        end else begin
          lane_be   = 4'b0001 << addr[1:0];
          lane_data = {4{wdata[7:0]}};
        end
      end
      default: lane_be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = lane_be[i] ? lane_data[8*i +: 8] : rd_word[8*i +: 8];
    end
    commit = en && !reset && is_store(op) && !align_err && !range_err;
  end

  // Memory array: whole-array clear on reset, otherwise write the merged word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[widx] <= wr_word;
    end
  end

  // Trace next-state: load on commit, hold otherwise; valid pulses per commit.
  always_comb begin
    trace_valid_d = commit;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    if (commit) begin
      trace_pc_d   = pc;
      trace_addr_d = {addr[31:2], 2'b00};
      trace_data_d = wr_word;
    end
  end

  // Trace registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule
